axilite_mmio_responder: RTL
===========================

# axilite_mmio_responder

AXI4-Lite slave that terminates the uncore's MMIO master port on the uncore clock. It exposes a small control/status register bank:
- ID
- scratch
- LED control
- DMA interrupt pending/enable with aggregated interrupt output
- 64-bit cycle counter with coherent snapshot

It gives software bring-up and interrupt visibility without involving the PS.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width; offset decode uses addr[11:2] (4 KiB window, aliased above).
- DATA_WIDTH, 32, fixed; other values are unsupported.
- ID_VALUE, 32'h4C564E41, constant returned at offset 0x00.

Ports:
- uncoreclk  in  1  sole clock.
- uncore_rstn  in  1  asynchronous active-low reset.
- s_axi_aw{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  write address.
- s_axi_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  write data.
- s_axi_b{resp,valid,ready}  out/out/in  2/1/1  write response.
- s_axi_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  read address.
- s_axi_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  read data.
- intr_in  in  2  level interrupts (bit0 mm2s, bit1 s2mm), synchronous to uncoreclk.
- led_o  out  8  LED register contents.
- irq_o  out  1  registered OR of (pending & enable).

## Operation
Register map (offset, access, reset value):
- 0x00 ID, RO: ID_VALUE.
- 0x04 SCRATCH, RW: 0.
- 0x08 LED, RW [7:0]: 0; upper bits read 0.
- 0x0C PENDING, W1C [1:0]: 0. A bit sets on a rising edge of intr_in[i] (a previous-value flop detects the edge).
- 0x10 ENABLE, RW [1:0]: 0.
- 0x14 CYCLE_LO, RO: 64-bit free-running counter, 0 at reset, wraps 2^64-1→0. A read returns cnt[31:0] and the same edge latches cnt[63:32] into a shadow register.
- 0x18 CYCLE_HI, RO: returns the shadow (0 at reset).
- Any other offset → DECERR (2'b11), read data 0, no side effects.

Access and response rules:
- Write to a RO offset → SLVERR (2'b10), no effect. All other accesses return OKAY.
- wstrb is honoured per byte on RW registers. PENDING/ENABLE use only strb[0].
- Same-edge hardware set and W1C on a PENDING bit: set wins.

Write path:
- AW and W are accepted independently into one-deep buffers.
- awready = ~aw_buf_full & ~bvalid & rdy_en; wready likewise.
- The write commits on the edge where both address and data are available (buffered, or handshaking that cycle) and bvalid=0.
- At the commit edge: bvalid←1 and bresp is set; buffers clear. bvalid holds until bready.

Read path:
- arready = ~rvalid & rdy_en.
- On the AR handshake edge: rdata/rresp are captured and rvalid←1. rvalid holds, data stable, until rready.
- One read and one write may be outstanding concurrently.

Simultaneous events:
- Read capture and write commit on the same edge to the same register: the read returns the pre-write value.
- A read of PENDING has no side effects.

## Timing
- Reset (async assert, synchronous release): all outputs 0, including awready/wready/arready.
- rdy_en goes to 1 on the first uncoreclk edge after release.
- Write with AW+W in cycle 0: commit at the end of cycle 0, bvalid=1 in cycle 1; next AW/W is acceptable in the cycle after bready.
- Read: AR in cycle 0, rvalid=1 in cycle 1. Throughput is 1 read per 2 cycles with rready held high.
- irq_o: one cycle after the PENDING/ENABLE update, so an intr_in edge in cycle 0 gives PENDING=1 in cycle 1 and irq_o=1 in cycle 2.
- Reset mid-transaction discards buffers and pending responses with no completion issued.

## Structure
- Package mmio_regs_pkg holds:
  - register offset localparams
  - RESP_OKAY/SLVERR/DECERR
  - default ID_VALUE
  - the intr index names
- Sub-module mmio_chan_buf: one-deep valid/ready holding buffer, instantiated for AW (addr) and W (data+strb).

## Test plan
- Reset, then read 0x00 → rdata 32'h4C564E41, rresp 0, rvalid in the cycle after the AR handshake.
- Write 0x04=32'hDEADBEEF with wstrb=4'b0101, W sent 3 cycles before AW → read 0x04 returns 32'h00AD00EF; bresp OKAY; exactly one B.
- Write 0x08=32'hA5 → led_o=8'hA5 in the cycle after commit. Hold bready=0 for 5 cycles → awready stays 0 and bvalid holds.
- ENABLE=2'b01, pulse intr_in[0] → irq_o=1 two cycles later. W1C 0x0C=1 on the same edge as a new intr_in[0] rise → PENDING stays 1.
- Force the counter to 64'h0000_0001_FFFF_FFFF: read LO returns FFFFFFFF, then read HI returns 1 even after the counter carries.
- Read 0x1C → DECERR, data 0. Write 0x00 → SLVERR, ID unchanged. Assert reset with bvalid pending → bvalid=0 immediately.

Source files
------------

// File: rtl/mmio_regs_pkg.sv
// rtl/mmio_regs_pkg.sv - register map, response codes and helpers for the MMIO responder
package mmio_regs_pkg;

  localparam logic [9:0] OFF_ID       = 10'h000;
  localparam logic [9:0] OFF_SCRATCH  = 10'h001;
  localparam logic [9:0] OFF_LED      = 10'h002;
  localparam logic [9:0] OFF_PENDING  = 10'h003;
  localparam logic [9:0] OFF_ENABLE   = 10'h004;
  localparam logic [9:0] OFF_CYCLE_LO = 10'h005;
  localparam logic [9:0] OFF_CYCLE_HI = 10'h006;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4C564E41;

  localparam int INTR_MM2S = 0;
  localparam int INTR_S2MM = 1;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_chan_buf.sv
// rtl/mmio_chan_buf.sv - one-deep valid/ready holding buffer with same-cycle pass-through
module mmio_chan_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         consume_i
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = ~full_q & en_i;
  // Data is usable either from the buffer or straight off the bus in its handshake cycle.
  assign out_valid_o = full_q | (in_valid_i & in_ready_o);
  assign out_data_o  = full_q ? data_q : in_data_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (consume_i) begin
      full_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axilite_mmio_responder.sv
// rtl/axilite_mmio_responder.sv - AXI4-Lite control/status register bank with IRQ aggregation and cycle counter
module axilite_mmio_responder
  import mmio_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                    uncoreclk,
  input  logic                    uncore_rstn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [1:0]              intr_in,
  output logic [7:0]              led_o,
  output logic                    irq_o
);

  logic        rdy_en_q;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  en_q, en_d;
  logic [1:0]  intr_prev_q;
  logic        irq_q;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  logic        buf_en;
  logic        aw_avail, w_avail, commit;
  logic [9:0]  aw_off, ar_off;
  logic [35:0] w_pkt;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [1:0]  w1c, intr_rise, wr_resp;
  logic        ar_hs;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_awaddr[1:0],
                              s_axi_araddr[ADDR_WIDTH-1:12], s_axi_araddr[1:0]};

  assign buf_en = ~bvalid_q & rdy_en_q;
  assign commit = aw_avail & w_avail & ~bvalid_q;

  mmio_chan_buf #(.W(10)) u_aw_buf (
    .clk_i       (uncoreclk),
    .rst_ni      (uncore_rstn),
    .en_i        (buf_en),
    .in_data_i   (s_axi_awaddr[11:2]),
    .in_valid_i  (s_axi_awvalid),
    .in_ready_o  (s_axi_awready),
    .out_data_o  (aw_off),
    .out_valid_o (aw_avail),
    .consume_i   (commit)
  );

  mmio_chan_buf #(.W(36)) u_w_buf (
    .clk_i       (uncoreclk),
    .rst_ni      (uncore_rstn),
    .en_i        (buf_en),
    .in_data_i   ({s_axi_wstrb, s_axi_wdata}),
    .in_valid_i  (s_axi_wvalid),
    .in_ready_o  (s_axi_wready),
    .out_data_o  (w_pkt),
    .out_valid_o (w_avail),
    .consume_i   (commit)
  );

  assign w_data    = w_pkt[31:0];
  assign w_strb    = w_pkt[35:32];
  assign intr_rise = intr_in & ~intr_prev_q;
  assign cnt_d     = cnt_q + 64'd1;

  always_comb begin
    scratch_d = scratch_q;
    led_d     = led_q;
    en_d      = en_q;
    w1c       = 2'b00;
    wr_resp   = RESP_OKAY;
    if (commit) begin
      case (aw_off)
        OFF_SCRATCH: scratch_d = apply_strb(scratch_q, w_data, w_strb);
        OFF_LED:     if (w_strb[0]) led_d = w_data[7:0];
        OFF_PENDING: if (w_strb[0]) w1c = w_data[1:0];
        OFF_ENABLE:  if (w_strb[0]) en_d = w_data[1:0];
        OFF_ID, OFF_CYCLE_LO, OFF_CYCLE_HI: wr_resp = RESP_SLVERR;
        default:     wr_resp = RESP_DECERR;
      endcase
    end
    // A fresh interrupt edge must survive a simultaneous clear.
    pend_d = (pend_q & ~w1c) | intr_rise;
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp;
    end else if (s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  assign s_axi_arready = ~rvalid_q & rdy_en_q;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign ar_off        = s_axi_araddr[11:2];

  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_OKAY;
    case (ar_off)
      OFF_ID:       rd_data = ID_VALUE;
      OFF_SCRATCH:  rd_data = scratch_q;
      OFF_LED:      rd_data = {24'h0, led_q};
      OFF_PENDING:  rd_data = {30'h0, pend_q};
      OFF_ENABLE:   rd_data = {30'h0, en_q};
      OFF_CYCLE_LO: rd_data = cnt_q[31:0];
      OFF_CYCLE_HI: rd_data = shadow_q;
      default:      rd_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    shadow_d = shadow_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
      // The high half is frozen on the low-half read so a LO-then-HI pair is coherent.
      if (ar_off == OFF_CYCLE_LO) shadow_d = cnt_q[63:32];
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      rdy_en_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= 32'h0;
      scratch_q   <= 32'h0;
      led_q       <= 8'h0;
      pend_q      <= 2'b00;
      en_q        <= 2'b00;
      intr_prev_q <= 2'b00;
      irq_q       <= 1'b0;
      cnt_q       <= 64'h0;
      shadow_q    <= 32'h0;
    end else begin
      rdy_en_q    <= 1'b1;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      led_q       <= led_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      intr_prev_q <= intr_in;
      irq_q       <= |(pend_q & en_q);
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign led_o        = led_q;
  assign irq_o        = irq_q;

endmodule
